// File: rtl/regfile_loader.sv
// Byte-stream loader for the CPU register file: assembles little-endian words
// and writes them to FIRST_REG..LAST_REG, stalling the CPU while active.
module regfile_loader #(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [4:0]  rw,
  output logic [31:0] busw,
  output logic        we,
  output logic        busy,
  output logic        cpu_stall,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [4:0] FIRST_IDX = FIRST_REG[4:0];
  localparam logic [4:0] LAST_IDX  = LAST_REG[4:0];

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [1:0]  byte_cnt;
  // Only the first three bytes are buffered; the fourth goes straight to busw.
  logic [23:0] word;
  logic        xfer;

  assign xfer = in_valid && (state == RECV);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RECV;
      RECV:    if (xfer && byte_cnt == 2'd3) state_nxt = WRITE;
      WRITE:   state_nxt = (idx == LAST_IDX) ? DONE : RECV;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      byte_cnt <= '0;
      word     <= '0;
      rw       <= '0;
      busw     <= '0;
    end else begin
      state <= state_nxt;
      if (!abort) begin
        case (state)
          IDLE: begin
            if (start) begin
              idx      <= FIRST_IDX;
              byte_cnt <= '0;
            end
          end
          RECV: begin
            if (xfer) begin
              byte_cnt <= byte_cnt + 2'd1;
              case (byte_cnt)
                2'd0: word[7:0]   <= in_data;
                2'd1: word[15:8]  <= in_data;
                2'd2: word[23:16] <= in_data;
                default: begin
                  rw   <= idx;
                  busw <= {in_data, word};
                end
              endcase
            end
          end
          WRITE: begin
            if (idx != LAST_IDX) begin
              idx      <= idx + 5'd1;
              byte_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // we/done decode the state register; abort suppresses them in its own cycle.
  always_comb begin
    in_ready  = (state == RECV);
    we        = (state == WRITE) && !abort;
    done      = (state == DONE) && !abort;
    busy      = (state == RECV) || (state == WRITE);
    cpu_stall = busy;
  end

endmodule
